// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: register addresses and the OAM DMA state encoding.
// Latency: n/a (constants, types and a small helper only).
// Backpressure: n/a.
package nes_bus_pkg;

    // Snooped trigger register; a CPU write here selects the source page.
    localparam logic [15:0] ADDR_SPR_RAM_DMA  = 16'h4014;
    // SPR-RAM data port; every DMA byte is written here.
    localparam logic [15:0] ADDR_SPR_RAM_DATA = 16'h2004;

    // ALIGN is only reachable when the parity-alignment build option is on.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        RD    = 3'd3,
        WR    = 3'd4,
        DONE  = 3'd5
    } dma_state_t;

    // Source address of byte cnt: the low counter byte never carries into the page.
    function automatic logic [15:0] page_addr(input logic [7:0] page, input logic [8:0] cnt);
        return {page, cnt[7:0]};
    endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU snoop, DMA master and shared memory-bus signals of the OAM DMA controller.
// Latency: n/a (wiring only).
// Backpressure: cpu_rdy low stalls the CPU while the DMA owns the bus.
interface oam_dma_ctrl_if;

    // Snooped CPU side
    logic [15:0] cpu_addr_out;
    logic [7:0]  cpu_data_out;
    logic        cpu_wen;
    logic        cpu_rdy;

    // DMA master side
    logic        bus_grant;
    logic [15:0] dma_addr_out;
    logic [7:0]  dma_data_out;
    logic        dma_ren;
    logic        dma_wen;
    logic [7:0]  dma_data_in;
    logic        dma_done;

    // Shared memory bus after the grant mux
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;

    // The DMA controller drives the master strobes, stall and the muxed bus.
    modport master (
        input  cpu_addr_out, cpu_data_out, cpu_wen, dma_data_in,
        output cpu_rdy, bus_grant, dma_addr_out, dma_data_out,
               dma_ren, dma_wen, dma_done, mem_addr, mem_wdata, mem_wen
    );

    // The system side (CPU core plus memory/IO decoder).
    modport slave (
        output cpu_addr_out, cpu_data_out, cpu_wen, dma_data_in,
        input  cpu_rdy, bus_grant, dma_addr_out, dma_data_out,
               dma_ren, dma_wen, dma_done, mem_addr, mem_wdata, mem_wen
    );

endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA: a CPU write to 4014h halts the CPU and copies XFER_LEN bytes of page into 2004h.
// Latency: HALT_CYCLES (+1 ALIGN with OAM_DMA_ALIGN_EN) + 2 cycles/byte, then one DONE cycle.
// Backpressure: none accepted; cpu_rdy=0 stalls the CPU for the whole transfer.
// Optional build macro OAM_DMA_ALIGN_EN: first read cycle always lands on even cycle parity.
module oam_dma_ctrl
    import nes_bus_pkg::*;
#(
    parameter int XFER_LEN    = 256,
    parameter int HALT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    oam_dma_ctrl_if.master bus
);

    localparam int          HW       = $clog2(HALT_CYCLES + 1);
    localparam logic [HW-1:0] HALT_LAST = HW'(HALT_CYCLES - 1);
    localparam logic [8:0]  CNT_LAST = 9'(XFER_LEN - 1);

    dma_state_t     state_q;
    logic [8:0]     cnt_q;
    logic [8:0]     cnt_d;
    logic [7:0]     page_q;
    logic [7:0]     data_q;
    logic [HW-1:0]  halt_q;
    logic [15:0]    addr_q;
    logic           cpu_rdy_q;
    logic           grant_q;
    logic           ren_q;
    logic           wen_q;
    logic           done_q;
    logic           trig;
    logic           need_align;

`ifdef OAM_DMA_ALIGN_EN
    logic           parity_q;

    // Free-running cycle parity; the cycle after reset is even.
    always_ff @(posedge clk) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= ~parity_q;
    end

    // Leaving HALT on an even cycle would put RD on an odd one, so detour via ALIGN.
    assign need_align = ~parity_q;
`else
    assign need_align = 1'b0;
`endif

    // Trigger decode and the incremented byte counter.
    always_comb begin
        trig  = bus.cpu_wen && (bus.cpu_addr_out == ADDR_SPR_RAM_DMA);
        cnt_d = cnt_q + 9'd1;
    end

    // Transfer FSM with registered bus outputs set for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 9'd0;
            page_q    <= 8'h00;
            data_q    <= 8'h00;
            halt_q    <= '0;
            addr_q    <= 16'h0000;
            cpu_rdy_q <= 1'b1;
            grant_q   <= 1'b0;
            ren_q     <= 1'b0;
            wen_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (trig) begin
                        page_q    <= bus.cpu_data_out;
                        halt_q    <= '0;
                        cpu_rdy_q <= 1'b0;
                        grant_q   <= 1'b1;
                        state_q   <= HALT;
                    end
                end
                HALT: begin
                    if (halt_q == HALT_LAST) begin
                        if (need_align) begin
                            state_q <= ALIGN;
                        end else begin
                            ren_q   <= 1'b1;
                            addr_q  <= page_addr(page_q, cnt_q);
                            state_q <= RD;
                        end
                    end else begin
                        halt_q <= halt_q + 1'b1;
                    end
                end
                ALIGN: begin
                    ren_q   <= 1'b1;
                    addr_q  <= page_addr(page_q, cnt_q);
                    state_q <= RD;
                end
                RD: begin
                    // Read data is combinational, so it is captured at the end of RD.
                    data_q  <= bus.dma_data_in;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b1;
                    addr_q  <= ADDR_SPR_RAM_DATA;
                    state_q <= WR;
                end
                WR: begin
                    cnt_q <= cnt_d;
                    wen_q <= 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        cpu_rdy_q <= 1'b1;
                        grant_q   <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        ren_q   <= 1'b1;
                        addr_q  <= page_addr(page_q, cnt_d);
                        state_q <= RD;
                    end
                end
                DONE: begin
                    // A 4014h write during DONE is deliberately not looked at.
                    cnt_q   <= 9'd0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_rdy      = cpu_rdy_q;
    assign bus.bus_grant    = grant_q;
    assign bus.dma_addr_out = addr_q;
    assign bus.dma_data_out = data_q;
    assign bus.dma_ren      = ren_q;
    assign bus.dma_wen      = wen_q;
    assign bus.dma_done     = done_q;

    // Shared bus mux: the DMA master owns address, data and write strobe while granted.
    always_comb begin
        bus.mem_addr  = grant_q ? addr_q : bus.cpu_addr_out;
        bus.mem_wdata = grant_q ? data_q : bus.cpu_data_out;
        bus.mem_wen   = grant_q ? wen_q  : bus.cpu_wen;
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Bus initiator for the SPR-RAM DMA register at 4014h.
- Snoops CPU writes to 4014h, halts the CPU and takes over the CPU memory bus.
- Copies 256 bytes from CPU page {page,00h}..{page,FFh} into SPR-RAM data register 2004h: one read cycle and one write cycle per byte.
- Sits between the CPU core and the memory/IO decoder; its master outputs are muxed onto the shared bus by bus_grant.

Parameters:
- XFER_LEN, 256, number of bytes per DMA transfer (range 1..256).
- HALT_CYCLES, 1, dummy cycles between trigger and first read.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- cpu_addr_out  input  16  CPU bus address (snooped).
- cpu_data_out  input  8  CPU write data (snooped).
- cpu_wen  input  1  CPU write strobe (snooped).
- cpu_rdy  output  1  1 = CPU may run; 0 = CPU stalled.
- bus_grant  output  1  1 = DMA master outputs drive the memory bus.
- dma_addr_out  output  16  DMA bus address.
- dma_data_out  output  8  DMA write data.
- dma_ren  output  1  DMA read strobe.
- dma_wen  output  1  DMA write strobe.
- dma_data_in  input  8  read data; combinational, valid in the same cycle as dma_ren.
- dma_done  output  1  single-cycle pulse after the last write.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - cpu_rdy=1.
  - bus_grant=0, dma_ren=0, dma_wen=0, dma_done=0.
  - dma_addr_out=0000h, dma_data_out=00h.
  - State IDLE; byte counter=0; page register=00h.
- Trigger:
  - In IDLE, a cycle with cpu_wen=1 and cpu_addr_out==4014h captures cpu_data_out into page.
  - At the next edge the FSM moves to HALT.
  - The CPU write itself completes normally in the trigger cycle.
- States:
  - IDLE: all master outputs inactive; cpu_rdy=1.
  - HALT: cpu_rdy=0, bus_grant=1, no strobes. Lasts HALT_CYCLES cycles, then goes to RD.
  - RD: dma_ren=1, dma_addr_out={page,cnt[7:0]}. At the edge, dma_data_in is latched into a data register and the FSM goes to WR.
  - WR: dma_wen=1, dma_addr_out=2004h, dma_data_out=latched byte. At the edge, cnt increments.
    - If cnt==XFER_LEN-1, go to DONE.
    - Otherwise go to RD.
  - DONE: one cycle, dma_done=1, bus_grant=0, cpu_rdy=1. Then go to IDLE, with cnt cleared.
- Latency (default parameters):
  - Trigger edge to first dma_ren: 1 HALT cycle.
  - Full transfer: 1 + 2*256 = 513 stalled cycles, then 1 DONE cycle.
- Arithmetic:
  - cnt is 9 bits. The low 8 bits form the address; there is no carry into the page byte.
  - The page byte FFh is legal and reads FF00h..FFFFh.
- cpu_rdy=0 and bus_grant=1 hold in HALT, RD and WR only.
- Strobes are mutually exclusive; dma_ren and dma_wen are never both 1.
- Boundaries and simultaneous events:
  - A 4014h write while not in IDLE is ignored. The page is not updated and the transfer is not restarted.
  - Other CPU writes (e.g. 4015h, 2004h) never trigger.
  - A trigger in the same cycle as DONE is ignored. A trigger accepted in the IDLE cycle after DONE starts a new transfer.
  - rst asserted mid-transfer: at the next edge, all outputs take their reset values and the FSM returns to IDLE. The partial transfer is abandoned and dma_done is not pulsed.
  - XFER_LEN=1: HALT, RD, WR, DONE.

Optional Feature:
- Macro OAM_DMA_ALIGN_EN.
- When defined:
  - A free-running 1-bit cycle parity toggles every clk and is cleared by rst.
  - If HALT would exit into RD on an odd-parity cycle, one extra ALIGN cycle is inserted: cpu_rdy=0, bus_grant=1, no strobes.
  - RD therefore always starts on even parity, giving 513 or 514 stalled cycles.
- When undefined:
  - There is no parity register and no ALIGN state.
  - The stall is always 1 + HALT_CYCLES-1 + 2*XFER_LEN cycles.

Decomposition:
- Shared package nes_bus_pkg holds:
  - Address constants ADDR_SPR_RAM_DMA (4014h) and ADDR_SPR_RAM_DATA (2004h).
  - The dma_state_t enum: IDLE, HALT, ALIGN, RD, WR, DONE.
- No sub-module. The FSM, counter and data latch form one block; the bus mux lives in the top level.

Test Plan:
- Preload RAM 0200h..02FFh with the value (i XOR A5h); CPU writes 02h to 4014h -> cpu_rdy low for 513 cycles; 256 writes to 2004h with data (i XOR A5h), in order; dma_done is a single pulse.
- Page FFh -> reads FF00h..FFFFh from ROM; no address wrap into page 00h; last read address is FFFFh.
- CPU writes 4015h and 4016h, and reads 4014h -> no transfer; cpu_rdy stays 1.
- Assert rst at the 100th WR -> next cycle: cpu_rdy=1, bus_grant=0, no dma_done; a later write of 03h to 4014h performs a full clean transfer from 0300h.
- Back-to-back: a trigger in the cycle after DONE is accepted; a trigger during DONE is ignored. Check both.
- With OAM_DMA_ALIGN_EN defined: trigger on an even and then an odd parity cycle -> stalls of 513 and 514 cycles; the first dma_ren is always on even parity.
